// File: rtl/keypad_button_encoder_if.sv
// Keypad-side signal bundle for the button encoder: matrix rows/columns plus the
// one-cycle button code and the held flag handed to the calculator FSM.
interface keypad_button_encoder_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [9:0] button;
    logic       key_held;

    modport master (
        input  row_n,
        output col_n,
        output button,
        output key_held
    );

    modport slave (
        output row_n,
        input  col_n,
        input  button,
        input  key_held
    );
endinterface

// File: rtl/keypad_button_encoder.sv
// 4x4 active-low keypad scanner with scan-level debounce; emits one-cycle
// calculator button codes for single accepted key presses.
module keypad_button_encoder #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    keypad_button_encoder_if.master kp
);
    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);
    localparam logic [4:0]  DS_LAST  = 5'(DEBOUNCE_SCANS);
    localparam logic        DS_ONE   = (DEBOUNCE_SCANS == 32'sd1);

    function automatic logic is_onehot(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

    // Vector bit r*4+c maps to the key at row r, column c.
    function automatic logic [9:0] key_code(input logic [15:0] v);
        case (v)
            16'h0001: key_code = 10'b00_0000_0010;
            16'h0002: key_code = 10'b00_0000_0100;
            16'h0004: key_code = 10'b00_0000_1000;
            16'h0008: key_code = 10'b10_0000_0001;
            16'h0010: key_code = 10'b00_0001_0000;
            16'h0020: key_code = 10'b00_0010_0000;
            16'h0040: key_code = 10'b00_0100_0000;
            16'h0080: key_code = 10'b10_0000_0010;
            16'h0100: key_code = 10'b00_1000_0000;
            16'h0200: key_code = 10'b01_0000_0000;
            16'h0400: key_code = 10'b01_0000_0001;
            16'h0800: key_code = 10'b10_0000_0100;
            16'h1000: key_code = 10'b11_1000_0000;
            16'h2000: key_code = 10'b00_0000_0001;
            16'h4000: key_code = 10'b11_0000_0000;
            16'h8000: key_code = 10'b10_0000_1000;
            default:  key_code = 10'd0;
        endcase
    endfunction

    logic [3:0]  row_meta_q, row_sync_q;
    logic [15:0] div_q, div_d;
    logic [1:0]  col_q, col_d;
    logic [3:0]  col_n_q, col_n_d;
    logic [15:0] work_q, work_d;
    logic [15:0] snapshot_q, snapshot_d;
    logic        scan_done_q, scan_done_d;
    logic        col_last_s;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] cand_q, cand_d;
    logic [9:0]  button_q, button_d;
    logic        key_held_q, key_held_d;
    logic        snap_match_s, cnt_hit_s, accept_s, rel_done_s;
    logic [4:0]  cnt_inc_s;

    assign col_last_s = (div_q == DIV_LAST);

    // Scanner next state: column timing, per-column row capture, scan completion.
    always_comb begin
        div_d       = div_q + 16'd1;
        col_d       = col_q;
        col_n_d     = col_n_q;
        work_d      = work_q;
        snapshot_d  = snapshot_q;
        scan_done_d = 1'b0;
        if (col_last_s) begin
            div_d   = 16'd0;
            col_d   = col_q + 2'd1;
            col_n_d = ~(4'b0001 << (col_q + 2'd1));
            for (int r = 0; r < 4; r++) begin
                work_d[{r[1:0], col_q}] = ~row_sync_q[r];
            end
            if (col_q == 2'd3) begin
                snapshot_d  = work_d;
                scan_done_d = 1'b1;
            end else begin
                scan_done_d = 1'b0;
            end
        end else begin
            div_d = div_q + 16'd1;
        end
    end

    // Scanner registers and the row synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= 4'd0;
            row_sync_q  <= 4'd0;
            div_q       <= 16'd0;
            col_q       <= 2'd0;
            col_n_q     <= 4'b1110;
            work_q      <= 16'd0;
            snapshot_q  <= 16'd0;
            scan_done_q <= 1'b0;
        end else begin
            row_meta_q  <= kp.row_n;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            col_q       <= col_d;
            col_n_q     <= col_n_d;
            work_q      <= work_d;
            snapshot_q  <= snapshot_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign snap_match_s = (snapshot_q == cand_q);
    assign cnt_inc_s    = {1'b0, cnt_q} + 5'd1;
    assign cnt_hit_s    = (cnt_inc_s == DS_LAST);
    assign accept_s     = scan_done_q &
                          (((state_q == ST_SCAN) & is_onehot(snapshot_q) & DS_ONE) |
                           ((state_q == ST_CONFIRM) & snap_match_s & cnt_hit_s));
    assign rel_done_s   = scan_done_q & (state_q == ST_RELEASE) &
                          (snapshot_q == 16'd0) & cnt_hit_s;

    // Debounce FSM state and data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_SCAN;
            cnt_q      <= 4'd0;
            cand_q     <= 16'd0;
            button_q   <= 10'd0;
            key_held_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            button_q   <= button_d;
            key_held_q <= key_held_d;
        end
    end

    // Debounce FSM next state; only a completed scan can move it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        if (scan_done_q) begin
            case (state_q)
                ST_SCAN: begin
                    if (is_onehot(snapshot_q)) begin
                        cand_d = snapshot_q;
                        if (DS_ONE) begin
                            cnt_d   = 4'd0;
                            state_d = ST_RELEASE;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = ST_CONFIRM;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_CONFIRM: begin
                    if (snap_match_s) begin
                        if (cnt_hit_s) begin
                            cnt_d   = 4'd0;
                            state_d = ST_RELEASE;
                        end else begin
                            cnt_d = cnt_inc_s[3:0];
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_SCAN;
                    end
                end
                ST_RELEASE: begin
                    if (snapshot_q == 16'd0) begin
                        if (cnt_hit_s) begin
                            cnt_d   = 4'd0;
                            state_d = ST_SCAN;
                        end else begin
                            cnt_d = cnt_inc_s[3:0];
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = ST_SCAN;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Debounce FSM outputs: single-cycle code on accept, held flag until release.
    always_comb begin
        button_d   = 10'd0;
        key_held_d = key_held_q;
        if (accept_s) begin
            button_d   = key_code(snapshot_q);
            key_held_d = 1'b1;
        end else if (rel_done_s) begin
            key_held_d = 1'b0;
        end else begin
            key_held_d = key_held_q;
        end
    end

    assign kp.col_n    = col_n_q;
    assign kp.button   = button_q;
    assign kp.key_held = key_held_q;
endmodule

// File: tb/tb_keypad_button_encoder.sv
// Directed bench for keypad_button_encoder: a key-matrix model drives the rows and a
// scoreboard queue holds the codes each press should produce.
module tb_keypad_button_encoder;
    localparam int SCAN = 16;
    localparam int K1 = 0, K2 = 1, K3 = 2, KPLUS = 3, K5 = 5, K7 = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  row_s;
    logic [9:0]  prev_btn;
    logic [9:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          pulses = 0;

    keypad_button_encoder_if kif();

    keypad_button_encoder #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a pressed key shorts its row to a driven-low column.
    always_comb begin
        row_s = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kif.col_n[c]) row_s[r] = 1'b0;
    end
    assign kif.row_n = row_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every nonzero code must match the next queued entry and last one cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_btn != 10'd0) check("pulse_width", 32'(kif.button), 32'd0);
            if (kif.button != 10'd0) begin
                pulses++;
                if (exp_q.size() == 0) check("unexpected_code", 32'(kif.button), 32'd0);
                else check("code", 32'(kif.button), 32'(exp_q.pop_front()));
            end
            prev_btn = kif.button;
        end else begin
            prev_btn = 10'd0;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_keys(input logic [15:0] k);
        @(negedge clk);
        keys = k;
    endtask

    task automatic wait_pulse(input string tag, input int target, input int budget, output int lat);
        lat = 0;
        while (pulses < target && lat < budget) begin
            @(negedge clk); #1;
            lat++;
        end
        check(tag, 32'(pulses), 32'(target));
    endtask

    task automatic wait_release(input string tag, input int budget);
        int n;
        n = 0;
        while (kif.key_held !== 1'b0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        check(tag, 32'(kif.key_held), 32'd0);
    endtask

    initial begin
        int lat;
        int n;
        logic kh_seen;
        int t2_key[5] = '{9, 10, 14, 12, 15};
        logic [9:0] t2_code[5] = '{10'b01_0000_0000, 10'b01_0000_0001, 10'b11_0000_0000,
                                   10'b11_1000_0000, 10'b10_0000_1000};
        keys = 16'd0;
        prev_btn = 10'd0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_col_n", 32'(kif.col_n), 32'h0000_000e);
        check("rst_button", 32'(kif.button), 32'd0);
        check("rst_key_held", 32'(kif.key_held), 32'd0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2 * SCAN);
        check("idle_no_pulse", 32'(pulses), 32'd0);

        // 1: key '5'
        exp_q.push_back(10'b00_0010_0000);
        set_keys(16'd1 << K5);
        wait_pulse("t1_pulse", 1, 60, lat);
        check("t1_latency", 32'(lat <= 51), 32'd1);
        cycles(SCAN); #1;
        check("t1_held", 32'(kif.key_held), 32'd1);
        cycles(3 * SCAN);
        check("t1_single", 32'(pulses), 32'd1);
        set_keys(16'd0);
        wait_release("t1_release", 3 * SCAN + 4);

        // 2: key sequence with releases
        for (int i = 0; i < 5; i++) begin
            cycles(2 * SCAN);
            exp_q.push_back(t2_code[i]);
            set_keys(16'd1 << t2_key[i]);
            wait_pulse("t2_pulse", 2 + i, 60, lat);
            cycles(SCAN);
            set_keys(16'd0);
            wait_release("t2_release", 60);
        end

        // 3: bounce shorter than the debounce window
        cycles(2 * SCAN);
        set_keys(16'd1 << K3);
        cycles(SCAN);
        keys = 16'd0;
        kh_seen = 1'b0;
        for (int i = 0; i < 4 * SCAN; i++) begin
            @(negedge clk);
            kh_seen = kh_seen | kif.key_held;
        end
        check("t3_no_pulse", 32'(pulses), 32'd6);
        check("t3_no_held", 32'(kh_seen), 32'd0);

        // 4: two keys together, then one released
        set_keys((16'd1 << K1) | (16'd1 << K2));
        cycles(5 * SCAN);
        check("t4_multi_none", 32'(pulses), 32'd6);
        exp_q.push_back(10'b00_0000_0100);
        set_keys(16'd1 << K2);
        wait_pulse("t4_pulse", 7, 60, lat);
        set_keys(16'd0);
        wait_release("t4_release", 60);

        // 5: long hold, short release, long release
        cycles(2 * SCAN);
        exp_q.push_back(10'b10_0000_0001);
        set_keys(16'd1 << KPLUS);
        cycles(10 * SCAN);
        check("t5_one_pulse", 32'(pulses), 32'd8);
        set_keys(16'd0);
        cycles(SCAN);
        keys = 16'd1 << KPLUS;
        cycles(4 * SCAN); #1;
        check("t5_no_repeat", 32'(pulses), 32'd8);
        check("t5_still_held", 32'(kif.key_held), 32'd1);
        set_keys(16'd0);
        cycles(3 * SCAN);
        exp_q.push_back(10'b10_0000_0001);
        keys = 16'd1 << KPLUS;
        wait_pulse("t5_second", 9, 60, lat);
        set_keys(16'd0);
        wait_release("t5_release", 60);

        // 6: reset during confirmation
        cycles(2 * SCAN);
        n = 0;
        while (kif.col_n !== 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (kif.col_n !== 4'b1110 && n < 80) begin @(negedge clk); n++; end
        check("t6_sync", 32'(kif.col_n), 32'h0000_000e);
        keys = 16'd1 << K7;
        cycles(20); #1;
        check("t6_confirm_not_held", 32'(kif.key_held), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t6_rst_button", 32'(kif.button), 32'd0);
        check("t6_rst_key_held", 32'(kif.key_held), 32'd0);
        check("t6_rst_col_n", 32'(kif.col_n), 32'h0000_000e);
        cycles(3);
        exp_q.push_back(10'b00_1000_0000);
        rst_n = 1'b1;
        wait_pulse("t6_pulse", 10, 60, lat);
        check("t6_fresh_debounce", 32'(lat >= 30 && lat <= 51), 32'd1);
        set_keys(16'd0);
        wait_release("t6_release", 60);

        cycles(2 * SCAN);
        check("total_pulses", 32'(pulses), 32'd10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/keypad_button_encoder.md
# keypad_button_encoder

- Scans a 4x4 active-low key matrix, synchronises and debounces the row returns, and emits one-cycle 10-bit button codes in the calculator's button encoding.
- It drives the `button` input of the calculator FSM directly, in place of bench stimulus.
- Each debounced press produces exactly one code pulse; otherwise the output is all zeros.

## Interface

Parameters:
- SCAN_DIV, 1000: clock cycles each column is driven; legal range 4..65535.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; legal range 1..15.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- row_n  in  4  matrix row returns, active-low (externally pulled up), asynchronous to clk.
- col_n  out  4  column drive, active-low, exactly one column low at any time.
- button  out  10  one-cycle button code, 0 when idle.
- key_held  out  1  high from an accepted press until its release is accepted.

## Operation

- **Key map** (row r, column c):
  - row0: 1 2 3 +
  - row1: 4 5 6 -
  - row2: 7 8 9 *
  - row3: C 0 = /
- **Codes**:
  - Digits 0..7: 00 followed by a one-hot in bits[7:0], where digit d sets bit d.
  - 8: 01_0000_0000. 9: 01_0000_0001.
  - + 10_0000_0001, - 10_0000_0010, * 10_0000_0100, / 10_0000_1000.
  - = 11_0000_0000. C 11_1000_0000.
- **Scanner**:
  - row_n passes through a 2-flop synchroniser.
  - A column counter drives col_n 1110, 1101, 1011, 0111 in turn, each for SCAN_DIV cycles, then wraps.
  - On the last cycle of each column period, the synchronised inverted rows are written into a 16-bit working vector at bits r*4+c.
  - After column 3 is sampled, the vector is copied to `snapshot` and `scan_done` pulses for one cycle.
  - The scanner never stalls.
- **FSM** (evaluated only on `scan_done`; holds state otherwise):
  - SCAN: if snapshot is one-hot, latch it as `cand`, set cnt=1 and go to CONFIRM; else stay. When DEBOUNCE_SCANS=1, emit immediately and go to RELEASE.
  - CONFIRM:
    - If snapshot==cand, cnt++.
    - When cnt reaches DEBOUNCE_SCANS, load `button` with the code for cand, set key_held=1 and go to RELEASE.
    - If snapshot!=cand (including zero or multi-key), clear cnt and go to SCAN. No re-latch occurs in the same cycle.
  - RELEASE:
    - If snapshot==0, cnt++; any nonzero snapshot clears cnt.
    - When cnt reaches DEBOUNCE_SCANS, set key_held=0, clear cnt and go to SCAN.
- **Multi-key**: snapshots with two or more keys down are never accepted. No code is emitted and there is no auto-repeat.
- **Reset** (rst_n low, asynchronous): col_n=1110, button=0, key_held=0, state SCAN, all counters and vectors 0, synchroniser 0. Scanning restarts at column 0 on the first edge after release.

## Timing

- One full scan takes 4*SCAN_DIV cycles. `scan_done` is one cycle wide, on the edge after the column-3 sample.
- `button` is registered. It is nonzero for exactly one cycle, starting on the edge where the FSM accepts the press, and is forced to 0 on the next edge.
- Latency from row_n settling low to `button` nonzero: between DEBOUNCE_SCANS*4*SCAN_DIV+3 and (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles, depending on scan phase.
- key_held rises in the same cycle as the `button` pulse. It falls on the edge where the release is accepted.
- Minimum spacing between two pulses: 2*DEBOUNCE_SCANS full scans.

## Test plan

All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=2.

1. Hold key '5' (r1,c1) steady → exactly one `button`=00_0010_0000 pulse, 1 cycle wide, within 51 cycles. key_held=1 while held. key_held falls within 2 scans plus one partial scan of release.
2. Hold '8', then '9', '=', 'C', '/' one at a time with releases between → pulses 01_0000_0000, 01_0000_0001, 11_0000_0000, 11_1000_0000, 10_0000_1000 in order, and no other nonzero codes.
3. Bounce: '3' down for one full scan only, then up → no pulse; key_held stays 0.
4. Keys '1' and '2' held together for 5 scans → no pulse. Release '1' → single pulse 00_0000_0100 after 2 matching scans.
5. Hold '+' for 10 scans → one pulse 10_0000_0001 only.
   - Release for 1 scan, then re-press → no second pulse.
   - Release for 3 scans, then re-press → second pulse.
6. Assert rst_n low mid-CONFIRM while '7' is held → button=0, key_held=0 and col_n=1110 immediately. After rst_n rises with '7' still held → one pulse 00_1000_0000 after a fresh full debounce.
